// File: rtl/img_ctrl_if.sv
// Host command, status, core handshake and frame-buffer write signals of img_ctrl_unit.
interface img_ctrl_if;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic        cmd_ready;
  logic        busy;
  logic        op_done;
  logic        err_invalid;
  logic        err_timeout;
  logic        core_start;
  logic [1:0]  core_mode;
  logic        core_done;
  logic [18:0] core_dest_addr;
  logic [7:0]  core_dest_data;
  logic        core_dest_wr_en;
  logic [18:0] dest_mem_addr;
  logic [7:0]  dest_mem_data_out;
  logic        dest_mem_wr_en;

  modport slave (
    input  cmd_valid, cmd_op, core_done, core_dest_addr, core_dest_data, core_dest_wr_en,
    output cmd_ready, busy, op_done, err_invalid, err_timeout, core_start, core_mode,
           dest_mem_addr, dest_mem_data_out, dest_mem_wr_en
  );

  modport master (
    output cmd_valid, cmd_op, core_done, core_dest_addr, core_dest_data, core_dest_wr_en,
    input  cmd_ready, busy, op_done, err_invalid, err_timeout, core_start, core_mode,
           dest_mem_addr, dest_mem_data_out, dest_mem_wr_en
  );
endinterface

// File: rtl/img_ctrl_unit.sv
// Image operation controller: decodes host commands, runs the frame clear engine,
// sequences the processing core with a timeout, and arbitrates the frame-buffer write port.
module img_ctrl_unit #(
  parameter int unsigned FRAME_PIXELS   = 307200,
  parameter logic [7:0]  CLEAR_VALUE    = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  img_ctrl_if.slave   bus
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CLR_W  = 19;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(FRAME_PIXELS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_COPY     = 3'b000;
  localparam logic [2:0] OP_ZOOM_IN  = 3'b001;
  localparam logic [2:0] OP_ZOOM_OUT = 3'b010;
  localparam logic [2:0] OP_AVG      = 3'b011;
  localparam logic [2:0] OP_CLEAR    = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CLR_W-1:0]  clear_cnt_q, clear_cnt_d;
  logic [TO_W-1:0]   run_cnt_q, run_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              zoom_q, zoom_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              inv_q, inv_d;
  logic              to_q, to_d;
  logic              ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clear_cnt_q <= '0;
      run_cnt_q   <= '0;
      mode_q      <= 2'd0;
      zoom_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      inv_q       <= 1'b0;
      to_q        <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      run_cnt_q   <= run_cnt_d;
      mode_q      <= mode_d;
      zoom_q      <= zoom_d;
      start_q     <= start_d;
      done_q      <= done_d;
      inv_q       <= inv_d;
      to_q        <= to_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state and registered-output logic; status pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    run_cnt_d   = run_cnt_q;
    mode_d      = mode_q;
    zoom_d      = zoom_q;
    done_d      = 1'b0;
    inv_d       = 1'b0;
    to_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_COPY, OP_ZOOM_IN, OP_AVG: begin
              state_d   = S_RUN;
              mode_d    = bus.cmd_op[1:0];
              run_cnt_d = '0;
            end
            OP_ZOOM_OUT: begin
              state_d     = S_CLEAR;
              mode_d      = 2'd2;
              zoom_d      = 1'b1;
              clear_cnt_d = '0;
            end
            OP_CLEAR: begin
              state_d     = S_CLEAR;
              zoom_d      = 1'b0;
              clear_cnt_d = '0;
            end
            default: inv_d = 1'b1;
          endcase
        end
      end

      S_CLEAR: begin
        if (clear_cnt_q == CLR_LAST) begin
          clear_cnt_d = '0;
          if (zoom_q) begin
            state_d   = S_RUN;
            run_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          clear_cnt_d = clear_cnt_q + CLR_W'(1);
        end
      end

      S_RUN: begin
        // Completion beats a coincident timeout.
        if (bus.core_done) begin
          state_d   = S_IDLE;
          run_cnt_d = '0;
          done_d    = 1'b1;
        end else if (run_cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          run_cnt_d = '0;
          to_d      = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + TO_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_RUN);
    ready_d = (state_d == S_IDLE);
  end

  // Frame-buffer write arbitration follows the current state only.
  always_comb begin
    bus.dest_mem_wr_en    = 1'b0;
    bus.dest_mem_addr     = '0;
    bus.dest_mem_data_out = '0;
    case (state_q)
      S_CLEAR: begin
        bus.dest_mem_wr_en    = 1'b1;
        bus.dest_mem_addr     = ADDR_W'(clear_cnt_q);
        bus.dest_mem_data_out = DATA_W'(CLEAR_VALUE);
      end
      S_RUN: begin
        bus.dest_mem_wr_en    = bus.core_dest_wr_en;
        bus.dest_mem_addr     = bus.core_dest_addr;
        bus.dest_mem_data_out = bus.core_dest_data;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.busy        = !ready_q;
  assign bus.core_start  = start_q;
  assign bus.core_mode   = mode_q;
  assign bus.op_done     = done_q;
  assign bus.err_invalid = inv_q;
  assign bus.err_timeout = to_q;

endmodule

// File: tb/tb_img_ctrl_unit.sv
// Directed bench for img_ctrl_unit with FRAME_PIXELS=16 and TIMEOUT_CYCLES=100.
module tb_img_ctrl_unit;

  logic clk;
  logic reset;
  img_ctrl_if bus();

  img_ctrl_unit #(
    .FRAME_PIXELS   (16),
    .CLEAR_VALUE    (8'h00),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-command observations
  int r_clear, r_run, r_pass, r_mode, r_done, r_inv, r_to, r_bad, r_leak, r_rdy, r_hang;

  typedef struct {
    logic [2:0] op;
    int done_at;
    int exp_clear;
    int exp_run;
    int exp_mode;
    int exp_done;
    int exp_inv;
    int exp_to;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and observe until the block has been idle for three cycles.
  task automatic run_cmd(input logic [2:0] op, input int done_at);
    int tail;
    r_clear = 0; r_run = 0; r_pass = 0; r_mode = -1; r_done = 0; r_inv = 0;
    r_to = 0; r_bad = 0; r_leak = 0; r_rdy = 0; r_hang = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_op = 3'b100;
    tail = 0;
    for (int k = 0; k < 400 && tail < 3; k++) begin
      if (bus.cmd_ready == bus.busy) r_rdy++;
      if (bus.dest_mem_wr_en) begin
        if (!bus.busy) r_leak++;
        else if (bus.core_start) begin
          if (bus.dest_mem_addr == 19'h05A5A && bus.dest_mem_data_out == 8'hC3) r_pass++;
          else r_bad++;
        end else begin
          if (int'(bus.dest_mem_addr) != r_clear || bus.dest_mem_data_out != 8'h00) r_bad++;
          r_clear++;
        end
      end
      if (bus.core_start) begin
        if (r_run == 0) r_mode = int'(bus.core_mode);
        r_run++;
      end
      r_done += int'(bus.op_done);
      r_inv  += int'(bus.err_invalid);
      r_to   += int'(bus.err_timeout);
      if (!bus.busy) tail++;
      // Hostile host keeps asserting a command while busy; it must be dropped.
      bus.cmd_valid = bus.busy;
      bus.core_done = bus.core_start && (r_run == done_at);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.core_done = 1'b0;
    if (tail < 3) r_hang = 1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"},   int'(bus.cmd_ready), 1);
    chk({tag, "_busy"},        int'(bus.busy), 0);
    chk({tag, "_core_start"},  int'(bus.core_start), 0);
    chk({tag, "_core_mode"},   int'(bus.core_mode), 0);
    chk({tag, "_pulses"},      int'(bus.op_done) + int'(bus.err_invalid) + int'(bus.err_timeout), 0);
    chk({tag, "_wr_en"},       int'(bus.dest_mem_wr_en), 0);
    chk({tag, "_addr"},        int'(bus.dest_mem_addr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int found;

    //          op      done  clr run mode done inv to
    vecs[0]  = '{3'b000,   5,  0,  5, 0, 1, 0, 0};
    vecs[1]  = '{3'b001,   3,  0,  3, 1, 1, 0, 0};
    vecs[2]  = '{3'b011,   1,  0,  1, 3, 1, 0, 0};
    vecs[3]  = '{3'b100,   0, 16,  0, 0, 1, 0, 0};
    vecs[4]  = '{3'b010,   4, 16,  4, 2, 1, 0, 0};
    vecs[5]  = '{3'b111,   0,  0,  0, 0, 0, 1, 0};
    vecs[6]  = '{3'b101,   0,  0,  0, 0, 0, 1, 0};
    vecs[7]  = '{3'b110,   0,  0,  0, 0, 0, 1, 0};
    vecs[8]  = '{3'b001,   0,  0, 100, 1, 0, 0, 1};
    vecs[9]  = '{3'b001, 100,  0, 100, 1, 1, 0, 0};
    vecs[10] = '{3'b000,  99,  0, 99, 0, 1, 0, 0};

    // Reset wins over a simultaneous command and core activity.
    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b000;
    bus.core_done = 1'b1;
    bus.core_dest_addr = 19'h05A5A;
    bus.core_dest_data = 8'hC3;
    bus.core_dest_wr_en = 1'b1;
    tick();
    tick();
    chk_reset_state("rst");
    reset = 1'b0;
    bus.cmd_valid = 1'b0;

    // core_done while idle is ignored; core writes never leak out of idle.
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(bus.op_done) + int'(bus.core_start) + int'(bus.dest_mem_wr_en) + int'(bus.busy);
    end
    chk("idle_core_done_ignored", pulses, 0);
    bus.core_done = 1'b0;

    for (int v = 0; v < 11; v++) begin
      run_cmd(vecs[v].op, vecs[v].done_at);
      chk($sformatf("v%0d_clear_writes", v), r_clear, vecs[v].exp_clear);
      chk($sformatf("v%0d_run_cycles", v),   r_run,   vecs[v].exp_run);
      chk($sformatf("v%0d_passthrough", v),  r_pass,  vecs[v].exp_run);
      if (vecs[v].exp_run > 0)
        chk($sformatf("v%0d_core_mode", v),  r_mode,  vecs[v].exp_mode);
      chk($sformatf("v%0d_op_done", v),      r_done,  vecs[v].exp_done);
      chk($sformatf("v%0d_err_invalid", v),  r_inv,   vecs[v].exp_inv);
      chk($sformatf("v%0d_err_timeout", v),  r_to,    vecs[v].exp_to);
      chk($sformatf("v%0d_bad_writes", v),   r_bad,   0);
      chk($sformatf("v%0d_idle_leak", v),    r_leak,  0);
      chk($sformatf("v%0d_ready_busy", v),   r_rdy,   0);
      chk($sformatf("v%0d_hang", v),         r_hang,  0);
    end

    // Reset at clear address 7 aborts silently; the next clear restarts at 0.
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b100;
    tick();
    bus.cmd_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (bus.dest_mem_wr_en && bus.dest_mem_addr == 19'd7) found = 1;
      else tick();
    end
    chk("midclear_reached_addr7", found, 1);
    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    tick();
    chk_reset_state("midclear_rst");
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(bus.op_done) + int'(bus.err_invalid) + int'(bus.err_timeout) + int'(bus.dest_mem_wr_en);
    end
    chk("midclear_no_pulse", pulses, 0);
    run_cmd(3'b100, 0);
    chk("reclear_writes", r_clear, 16);
    chk("reclear_bad", r_bad, 0);
    chk("reclear_done", r_done, 1);

    // Reset mid-RUN drops core_start and mode without any pulse.
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'b001;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("midrun_started", int'(bus.core_start) * 4 + int'(bus.core_mode), 5);
    reset = 1'b1;
    tick();
    chk_reset_state("midrun_rst");
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(bus.op_done) + int'(bus.err_invalid) + int'(bus.err_timeout) + int'(bus.core_start);
    end
    chk("midrun_no_pulse", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
